// File: rtl/dmux4way16_outport_if.sv
// Write port and four valid/ready channel bundle for the
// dmux4way16 output port bank.
interface dmux4way16_outport_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [1:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       valid;
  logic [3:0]       ready;
  logic [3:0]       ovf;
  logic [3:0]       ovf_clr;
  logic [7:0]       drop_cnt;

  modport master (
    output wr_en, wr_sel, wr_data,
    output ready, ovf_clr,
    input  wr_ready, a, b, c, d,
    input  valid, ovf, drop_cnt
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    input  ready, ovf_clr,
    output wr_ready, a, b, c, d,
    output valid, ovf, drop_cnt
  );
endinterface

// File: rtl/dmux4way16_outport.sv
// 4-channel output port bank: a write word is demuxed into one of
// four 1-deep holding registers, each drained by valid/ready.
module dmux4way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);
  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    unique case (1'b1)
      sel == 2'b00: a = in;
      sel == 2'b01: b = in;
      sel == 2'b10: c = in;
      default:      d = in;
    endcase
  end
endmodule

module dmux4way16_outport #(
  parameter int WIDTH     = 16,
  parameter int OVERWRITE = 0
) (
  input logic                 clk,
  input logic                 reset,
  dmux4way16_outport_if.slave bus
);
  localparam logic OW = (OVERWRITE != 0);

  logic [WIDTH-1:0] route  [4];
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic [3:0]       ovf_q;
  logic [7:0]       drop_q;
  logic [3:0]       hit;
  logic [3:0]       load;
  logic [3:0]       lost;
  logic             wr_ready;
  logic             accept;
  logic             loss;

  dmux4way16 #(.WIDTH(WIDTH)) u_dmux (
    .in  (bus.wr_data),
    .sel (bus.wr_sel),
    .a   (route[0]),
    .b   (route[1]),
    .c   (route[2]),
    .d   (route[3])
  );

  assign hit      = 4'b0001 << bus.wr_sel;
  assign wr_ready = !valid_q[bus.wr_sel]
                  | bus.ready[bus.wr_sel];
  assign accept   = bus.wr_en & (wr_ready | OW);
  assign loss     = bus.wr_en & ~wr_ready;
  assign load     = hit & {4{accept}};
  assign lost     = hit & {4{loss}};

  // A load wins over a drain so a same-cycle consume+write
  // keeps valid high with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      drop_q  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k]  <= route[k];
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] && bus.ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      ovf_q <= (ovf_q & ~bus.ovf_clr) | lost;
      if (loss && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.a        = data_q[0];
  assign bus.b        = data_q[1];
  assign bus.c        = data_q[2];
  assign bus.d        = data_q[3];
  assign bus.valid    = valid_q;
  assign bus.ovf      = ovf_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_dmux4way16_outport.sv
// Bench for dmux4way16_outport: drop and overwrite variants side
// by side against a per-channel reference model.
module tb_dmux4way16_outport;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmux4way16_outport_if #(.WIDTH(16)) bus0 ();
  dmux4way16_outport_if #(.WIDTH(16)) bus1 ();

  dmux4way16_outport #(.WIDTH(16), .OVERWRITE(0)) u_drop (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  dmux4way16_outport #(.WIDTH(16), .OVERWRITE(1)) u_ovwr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic [15:0] md [2][4];
  logic [3:0]  mv [2];
  logic [3:0]  mo [2];
  int          mc [2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input int v, input logic r,
                                input logic we,
                                input logic [1:0] s,
                                input logic [15:0] dt,
                                input logic [3:0] rd,
                                input logic [3:0] cl);
    bit full, rdy, lossy, take;
    if (r) begin
      for (int k = 0; k < 4; k++) md[v][k] = 16'h0;
      mv[v] = 4'h0;
      mo[v] = 4'h0;
      mc[v] = 0;
      return;
    end
    full  = mv[v][s];
    rdy   = !full || rd[s];
    lossy = we && !rdy;
    take  = we && (rdy || v == 1);
    for (int k = 0; k < 4; k++) begin
      if (take && int'(s) == k) begin
        md[v][k] = dt;
        mv[v][k] = 1'b1;
      end else if (mv[v][k] && rd[k]) begin
        mv[v][k] = 1'b0;
      end
    end
    mo[v] = mo[v] & ~cl;
    if (lossy) begin
      mo[v][s] = 1'b1;
      if (mc[v] < 255) mc[v] = mc[v] + 1;
    end
  endfunction

  task automatic state(input string p, input int v,
                       input logic [15:0] a, b, c, d,
                       input logic [3:0] vl, ov,
                       input logic [7:0] dc);
    chk({p, "_a"}, 32'(a), 32'(md[v][0]));
    chk({p, "_b"}, 32'(b), 32'(md[v][1]));
    chk({p, "_c"}, 32'(c), 32'(md[v][2]));
    chk({p, "_d"}, 32'(d), 32'(md[v][3]));
    chk({p, "_valid"}, 32'(vl), 32'(mv[v]));
    chk({p, "_ovf"}, 32'(ov), 32'(mo[v]));
    chk({p, "_drop"}, 32'(dc), 32'(mc[v]));
  endtask

  task automatic step(input logic r, we,
                      input logic [1:0] s,
                      input logic [15:0] dt,
                      input logic [3:0] rd, cl);
    logic e0, e1;
    @(negedge clk);
    reset        = r;
    bus0.wr_en   = we;
    bus0.wr_sel  = s;
    bus0.wr_data = dt;
    bus0.ready   = rd;
    bus0.ovf_clr = cl;
    bus1.wr_en   = we;
    bus1.wr_sel  = s;
    bus1.wr_data = dt;
    bus1.ready   = rd;
    bus1.ovf_clr = cl;
    #1;
    e0 = !mv[0][s] || rd[s];
    e1 = !mv[1][s] || rd[s];
    chk("drop_wr_ready", 32'(bus0.wr_ready), 32'(e0));
    chk("ovwr_wr_ready", 32'(bus1.wr_ready), 32'(e1));
    @(posedge clk);
    model(0, r, we, s, dt, rd, cl);
    model(1, r, we, s, dt, rd, cl);
    #1;
    state("drop", 0, bus0.a, bus0.b, bus0.c, bus0.d,
          bus0.valid, bus0.ovf, bus0.drop_cnt);
    state("ovwr", 1, bus1.a, bus1.b, bus1.c, bus1.d,
          bus1.valid, bus1.ovf, bus1.drop_cnt);
  endtask

  initial begin
    logic [3:0] rd, cl;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 4; k++) md[v][k] = 16'h0;
      mv[v] = 4'h0;
      mo[v] = 4'h0;
      mc[v] = 0;
    end

    // write to c after reset
    step(1, 0, 2'd0, 16'h0, 4'h0, 4'h0);
    chk("rst_valid", 32'(bus0.valid), 32'h0);
    step(0, 1, 2'd2, 16'h0001, 4'h0, 4'h0);
    chk("t1_c", 32'(bus0.c), 32'h0001);
    chk("t1_valid", 32'(bus0.valid), 32'h4);

    // second write to full a: drop vs overwrite
    step(1, 0, 2'd0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 2'd0, 16'h1234, 4'h0, 4'h0);
    step(0, 1, 2'd0, 16'h5678, 4'h0, 4'h0);
    chk("t2_a", 32'(bus0.a), 32'h1234);
    chk("t2_ovf", 32'(bus0.ovf), 32'h1);
    chk("t2_drop", 32'(bus0.drop_cnt), 32'h1);
    chk("t3_a", 32'(bus1.a), 32'h5678);
    chk("t3_ovf", 32'(bus1.ovf), 32'h1);
    chk("t3_drop", 32'(bus1.drop_cnt), 32'h1);

    // consume and refill d in one cycle
    step(1, 0, 2'd0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 2'd3, 16'hAAAA, 4'h0, 4'h0);
    step(0, 1, 2'd3, 16'hBBBB, 4'h8, 4'h0);
    chk("t4_d", 32'(bus0.d), 32'hBBBB);
    chk("t4_valid", 32'(bus0.valid), 32'h8);
    chk("t4_ovf", 32'(bus0.ovf), 32'h0);

    // drop counter saturation, then ovf clear
    step(1, 0, 2'd0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 2'd1, 16'h0BEE, 4'h0, 4'h0);
    for (int i = 0; i < 260; i++)
      step(0, 1, 2'd1, 16'(i), 4'h0, 4'h0);
    chk("t5_drop", 32'(bus0.drop_cnt), 32'd255);
    step(0, 0, 2'd1, 16'h0, 4'h0, 4'h2);
    chk("t5_ovf", 32'(bus0.ovf), 32'h0);

    // reset mid-handshake
    for (int k = 0; k < 4; k++)
      step(0, 1, 2'(k), 16'hC000 + 16'(k), 4'h0, 4'h0);
    step(1, 1, 2'd0, 16'hFFFF, 4'hF, 4'h0);
    chk("t6_valid", 32'(bus0.valid), 32'h0);
    chk("t6_drop", 32'(bus1.drop_cnt), 32'h0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rd = 4'($urandom);
      cl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      step($urandom_range(0, 63) == 0,
           1'($urandom),
           2'($urandom),
           16'($urandom),
           rd, cl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
